// File: rtl/banked_stack_pkg.sv
// Shared definitions for the banked stack address unit.
// Contents: command op encodings, fault codes, FSM state enum, the default
// region layout with its derived region tops, and a helper to compute a
// bank's top slot (one past the highest stack slot).
package banked_stack_pkg;

    typedef enum logic [1:0] {
        OP_PASS  = 2'd0,
        OP_PUSH  = 2'd1,
        OP_POP   = 2'd2,
        OP_SETSP = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        FAULT_NONE       = 3'd0,
        FAULT_OVERFLOW   = 3'd1,
        FAULT_UNDERFLOW  = 3'd2,
        FAULT_PROTECTION = 3'd3,
        FAULT_BAD_SP     = 3'd4
    } fault_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    localparam int DEF_CODE_AREA_SIZE  = 4096;
    localparam int DEF_PRIV_STACK_BASE = 4096;
    localparam int DEF_PRIV_STACK_SIZE = 2048;
    localparam int DEF_USER_STACK_BASE = 6144;
    localparam int DEF_USER_STACK_SIZE = 2048;

    // Full-descending stacks: the top is the empty-stack SP value.
    localparam int PRIV_TOP = DEF_PRIV_STACK_BASE + DEF_PRIV_STACK_SIZE;
    localparam int USER_TOP = DEF_USER_STACK_BASE + DEF_USER_STACK_SIZE;

    function automatic int region_top(input int base, input int size);
        return base + size;
    endfunction

endpackage

// File: rtl/banked_stack_address_unit_if.sv
// Command and memory-beat bus of the banked stack address unit.
// Command channel: cmd_valid/cmd_ready handshake with op, count, write flag
// and address. Memory channel: mem_valid/mem_ready handshake with beat
// address and last-beat flag.
// Modport slave  : the address unit (accepts commands, issues beats).
// Modport master : the surrounding control unit / memory side.
interface banked_stack_address_unit_if #(
    parameter int ADDR_WIDTH  = 14,
    parameter int DATA_WIDTH  = 32,
    parameter int BURST_WIDTH = 4
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [1:0]             cmd_op;
    logic [BURST_WIDTH-1:0] cmd_count;
    logic                   cmd_write;
    logic [DATA_WIDTH-1:0]  cmd_address;
    logic                   mem_valid;
    logic                   mem_ready;
    logic [ADDR_WIDTH-1:0]  mem_address;
    logic                   mem_last;

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_write, cmd_address, mem_ready,
        output cmd_ready, mem_valid, mem_address, mem_last
    );

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_write, cmd_address, mem_ready,
        input  cmd_ready, mem_valid, mem_address, mem_last
    );
endinterface

// File: rtl/banked_stack_address_unit_pc_sequencer.sv
// Program-counter register.
// Ports: clock, reset (sync, active-high), pc_stall (hold), pc_load (load
// pc_load_value, wins over stall), pc_load_value, pc (registered PC).
// Without load or stall the PC increments and wraps modulo 2^ADDR_WIDTH.
module pc_sequencer #(
    parameter int ADDR_WIDTH   = 14,
    parameter int RESET_VECTOR = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  pc_stall,
    input  logic                  pc_load,
    input  logic [ADDR_WIDTH-1:0] pc_load_value,
    output logic [ADDR_WIDTH-1:0] pc
);

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= ADDR_WIDTH'(RESET_VECTOR);
        end else if (pc_load) begin
            pc <= pc_load_value;
        end else if (!pc_stall) begin
            pc <= pc + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/banked_stack_address_unit.sv
// Banked stack address unit.
// Holds a user and a privileged full-descending stack pointer, checks each
// command at accept time (overflow, underflow, region protection, bad SP)
// and sequences PUSH/POP/PASS as one address beat per mem handshake.
// Ports: clock/reset (sync, active-high); privilege_mode_flag (bank select,
// sampled at accept); bus (command + memory beat channels); fault_valid
// (one-cycle pulse) and fault_code (held until the next fault); sp_user,
// sp_priv; pc_stall/pc_load/pc_load_value -> instruction_address.
module banked_stack_address_unit
    import banked_stack_pkg::*;
#(
    parameter int ADDR_WIDTH      = 14,
    parameter int DATA_WIDTH      = 32,
    parameter int BURST_WIDTH     = 4,
    parameter int CODE_AREA_SIZE  = DEF_CODE_AREA_SIZE,
    parameter int PRIV_STACK_BASE = DEF_PRIV_STACK_BASE,
    parameter int PRIV_STACK_SIZE = DEF_PRIV_STACK_SIZE,
    parameter int USER_STACK_BASE = DEF_USER_STACK_BASE,
    parameter int USER_STACK_SIZE = DEF_USER_STACK_SIZE,
    parameter int RESET_VECTOR    = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        privilege_mode_flag,
    banked_stack_address_unit_if.slave  bus,
    output logic                        fault_valid,
    output logic [2:0]                  fault_code,
    output logic [ADDR_WIDTH-1:0]       sp_user,
    output logic [ADDR_WIDTH-1:0]       sp_priv,
    input  logic                        pc_stall,
    input  logic                        pc_load,
    input  logic [ADDR_WIDTH-1:0]       pc_load_value,
    output logic [ADDR_WIDTH-1:0]       instruction_address
);

    localparam int USER_TOP_L = region_top(USER_STACK_BASE, USER_STACK_SIZE);
    localparam int PRIV_TOP_L = region_top(PRIV_STACK_BASE, PRIV_STACK_SIZE);

    state_e                 state;
    state_e                 state_next;
    logic                   bank_priv;
    op_e                    op_latched;
    logic [BURST_WIDTH-1:0] remaining;

    op_e                    op_in;
    logic [ADDR_WIDTH-1:0]  sp_sel;
    int                     base_sel;
    int                     top_sel;
    int                     free_words;
    int                     used_words;
    int                     count_words;
    logic                   addr_out_of_range;
    logic                   accept;
    logic                   start_burst;
    logic                   beat_fire;
    fault_e                 fault_sel;

    assign bus.cmd_ready = (state == ST_IDLE) && !reset;

    // Accept-time decode: bank selection and bound/protection checks.
    always_comb begin
        op_in             = op_e'(bus.cmd_op);
        sp_sel            = privilege_mode_flag ? sp_priv : sp_user;
        base_sel          = privilege_mode_flag ? PRIV_STACK_BASE : USER_STACK_BASE;
        top_sel           = privilege_mode_flag ? PRIV_TOP_L : USER_TOP_L;
        free_words        = 32'(sp_sel) - base_sel;
        used_words        = top_sel - 32'(sp_sel);
        count_words       = 32'(bus.cmd_count);
        addr_out_of_range = (bus.cmd_address >> ADDR_WIDTH) != '0;
        accept            = bus.cmd_valid && bus.cmd_ready;
        fault_sel         = FAULT_NONE;

        case (op_in)
            OP_PUSH: begin
                if (count_words > free_words) fault_sel = FAULT_OVERFLOW;
            end
            OP_POP: begin
                if (count_words > used_words) fault_sel = FAULT_UNDERFLOW;
            end
            OP_PASS: begin
                // User writes below the privileged-stack top would hit code or
                // the privileged stack.
                if (addr_out_of_range ||
                    (bus.cmd_write && !privilege_mode_flag &&
                     bus.cmd_address < DATA_WIDTH'(PRIV_TOP_L)))
                    fault_sel = FAULT_PROTECTION;
            end
            default: begin
                if (bus.cmd_address < DATA_WIDTH'(base_sel) ||
                    bus.cmd_address > DATA_WIDTH'(top_sel))
                    fault_sel = FAULT_BAD_SP;
            end
        endcase

        start_burst = accept && (fault_sel == FAULT_NONE) &&
                      ((op_in == OP_PASS) ||
                       (((op_in == OP_PUSH) || (op_in == OP_POP)) &&
                        (bus.cmd_count != '0)));
        beat_fire   = (state == ST_BURST) && bus.mem_valid && bus.mem_ready;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start_burst) state_next = ST_BURST;
            ST_BURST: if (beat_fire && bus.mem_last) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Stack pointers, beat sequencing and fault reporting.
    always_ff @(posedge clock) begin
        if (reset) begin
            sp_user         <= ADDR_WIDTH'(USER_TOP_L);
            sp_priv         <= ADDR_WIDTH'(PRIV_TOP_L);
            bus.mem_valid   <= 1'b0;
            bus.mem_last    <= 1'b0;
            bus.mem_address <= '0;
            fault_valid     <= 1'b0;
            fault_code      <= FAULT_NONE;
            bank_priv       <= 1'b0;
            op_latched      <= OP_PASS;
            remaining       <= '0;
        end else begin
            fault_valid <= 1'b0;

            if (accept) begin
                bank_priv  <= privilege_mode_flag;
                op_latched <= op_in;
                if (fault_sel != FAULT_NONE) begin
                    fault_valid <= 1'b1;
                    fault_code  <= fault_sel;
                end else if (op_in == OP_SETSP) begin
                    if (privilege_mode_flag) sp_priv <= bus.cmd_address[ADDR_WIDTH-1:0];
                    else                     sp_user <= bus.cmd_address[ADDR_WIDTH-1:0];
                end
            end

            if (start_burst) begin
                bus.mem_valid <= 1'b1;
                bus.mem_last  <= (op_in == OP_PASS) || (bus.cmd_count == BURST_WIDTH'(1));
                remaining     <= bus.cmd_count;
                case (op_in)
                    OP_PUSH: bus.mem_address <= sp_sel - ADDR_WIDTH'(1);
                    OP_POP:  bus.mem_address <= sp_sel;
                    default: bus.mem_address <= bus.cmd_address[ADDR_WIDTH-1:0];
                endcase
            end

            if (beat_fire) begin
                // SP tracks each accepted beat so a stalled beat leaves it untouched.
                if (op_latched == OP_PUSH) begin
                    if (bank_priv) sp_priv <= sp_priv - ADDR_WIDTH'(1);
                    else           sp_user <= sp_user - ADDR_WIDTH'(1);
                end else if (op_latched == OP_POP) begin
                    if (bank_priv) sp_priv <= sp_priv + ADDR_WIDTH'(1);
                    else           sp_user <= sp_user + ADDR_WIDTH'(1);
                end

                if (bus.mem_last) begin
                    bus.mem_valid <= 1'b0;
                    bus.mem_last  <= 1'b0;
                end else begin
                    bus.mem_address <= (op_latched == OP_PUSH) ?
                                       bus.mem_address - ADDR_WIDTH'(1) :
                                       bus.mem_address + ADDR_WIDTH'(1);
                    remaining       <= remaining - BURST_WIDTH'(1);
                    bus.mem_last    <= (remaining == BURST_WIDTH'(2));
                end
            end
        end
    end

    pc_sequencer #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_sequencer (
        .clock         (clock),
        .reset         (reset),
        .pc_stall      (pc_stall),
        .pc_load       (pc_load),
        .pc_load_value (pc_load_value),
        .pc            (instruction_address)
    );

endmodule

// File: tb/tb_banked_stack_address_unit.sv
// Self-checking bench for banked_stack_address_unit: directed scenarios and
// randomized commands compared against a behavioural stack/PC model.
module tb_banked_stack_address_unit;
    import banked_stack_pkg::*;

    localparam int AW = 14;

    logic          clock = 1'b0;
    logic          reset;
    logic          privilege_mode_flag;
    logic          fault_valid;
    logic [2:0]    fault_code;
    logic [AW-1:0] sp_user;
    logic [AW-1:0] sp_priv;
    logic          pc_stall;
    logic          pc_load;
    logic [AW-1:0] pc_load_value;
    logic [AW-1:0] instruction_address;

    always #5 clock = ~clock;

    banked_stack_address_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32), .BURST_WIDTH(4)) bus ();

    banked_stack_address_unit dut (
        .clock               (clock),
        .reset               (reset),
        .privilege_mode_flag (privilege_mode_flag),
        .bus                 (bus),
        .fault_valid         (fault_valid),
        .fault_code          (fault_code),
        .sp_user             (sp_user),
        .sp_priv             (sp_priv),
        .pc_stall            (pc_stall),
        .pc_load             (pc_load),
        .pc_load_value       (pc_load_value),
        .instruction_address (instruction_address)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    int m_sp_user;
    int m_sp_priv;
    int m_fault;
    int m_pc;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic int exp_fault(input bit priv, input int op, input int cnt,
                                     input bit wr, input logic [31:0] addr);
        int base;
        int top;
        int sp;
        base = priv ? 4096 : 6144;
        top  = base + 2048;
        sp   = priv ? m_sp_priv : m_sp_user;
        case (op)
            1: if (cnt > sp - base) return 1;
            2: if (cnt > top - sp) return 2;
            0: begin
                if (addr >= 32'd16384) return 3;
                if (wr && !priv && addr < 32'd6144) return 3;
            end
            default: if (addr < 32'(base) || addr > 32'(top)) return 4;
        endcase
        return 0;
    endfunction

    task automatic model_reset();
        m_sp_user = 8192;
        m_sp_priv = 6144;
        m_fault   = 0;
    endtask

    // Issue one command at posedge+1 and follow it to completion.
    task automatic do_cmd(input bit priv, input int op, input int cnt, input bit wr,
                          input logic [31:0] addr, input bit rnd_ready, input int stall_first);
        int f;
        int n;
        int sp0;
        int k;
        int cyc;
        int guard;
        int exp_addr;
        bit r;
        f   = exp_fault(priv, op, cnt, wr, addr);
        n   = 0;
        if (f == 0) begin
            if (op == 0) n = 1;
            else if (op == 1 || op == 2) n = cnt;
        end
        sp0 = priv ? m_sp_priv : m_sp_user;

        check_val("cmd_ready_idle", 32'(bus.cmd_ready), 1);
        privilege_mode_flag = priv;
        bus.cmd_valid       = 1'b1;
        bus.cmd_op          = 2'(op);
        bus.cmd_count       = 4'(cnt);
        bus.cmd_write       = wr;
        bus.cmd_address     = addr;
        @(posedge clock); #1;
        bus.cmd_valid       = 1'b0;
        privilege_mode_flag = 1'($urandom_range(0, 1));

        if (f != 0) begin
            m_fault = f;
            check_val("fault_valid_pulse", 32'(fault_valid), 1);
            check_val("fault_code", 32'(fault_code), 32'(f));
            check_val("fault_no_beat", 32'(bus.mem_valid), 0);
            @(posedge clock); #1;
            check_val("fault_valid_drop", 32'(fault_valid), 0);
        end else begin
            if (op == 3) begin
                if (priv) m_sp_priv = int'(addr);
                else      m_sp_user = int'(addr);
            end
            check_val("fault_valid_quiet", 32'(fault_valid), 0);
        end

        if (n == 0) check_val("no_beat", 32'(bus.mem_valid), 0);

        k = 0; cyc = 0; guard = 0;
        while (k < n && guard < 100) begin
            if (op == 1)      exp_addr = sp0 - 1 - k;
            else if (op == 2) exp_addr = sp0 + k;
            else              exp_addr = int'(addr[13:0]);
            check_val("mem_valid", 32'(bus.mem_valid), 1);
            check_val("mem_address", 32'(bus.mem_address), 32'(exp_addr));
            check_val("mem_last", 32'(bus.mem_last), 32'(k == n - 1));
            check_val("sp_during_burst", priv ? 32'(sp_priv) : 32'(sp_user),
                      priv ? 32'(m_sp_priv) : 32'(m_sp_user));
            if (k == 0 && cyc < stall_first) r = 1'b0;
            else if (rnd_ready)              r = ($urandom_range(0, 2) != 0);
            else                             r = 1'b1;
            bus.mem_ready = r;
            @(posedge clock); #1;
            if (r) begin
                k++;
                cyc = 0;
                if (op == 1) begin
                    if (priv) m_sp_priv--; else m_sp_user--;
                end else if (op == 2) begin
                    if (priv) m_sp_priv++; else m_sp_user++;
                end
            end else begin
                cyc++;
            end
            guard++;
        end
        bus.mem_ready = 1'b0;
        if (k < n) check_val("beat_budget", 32'(k), 32'(n));

        check_val("mem_valid_after", 32'(bus.mem_valid), 0);
        check_val("cmd_ready_after", 32'(bus.cmd_ready), 1);
        check_val("sp_user", 32'(sp_user), 32'(m_sp_user));
        check_val("sp_priv", 32'(sp_priv), 32'(m_sp_priv));
        check_val("fault_code_held", 32'(fault_code), 32'(m_fault));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int op;
        int cnt;
        int base;
        int top;
        int sel;
        bit priv;
        bit wr;
        bit ld;
        bit st;
        logic [31:0] addr;
        logic [AW-1:0] v;

        reset               = 1'b1;
        privilege_mode_flag = 1'b0;
        bus.cmd_valid       = 1'b0;
        bus.cmd_op          = 2'd0;
        bus.cmd_count       = 4'd0;
        bus.cmd_write       = 1'b0;
        bus.cmd_address     = 32'd0;
        bus.mem_ready       = 1'b0;
        pc_stall            = 1'b1;
        pc_load             = 1'b0;
        pc_load_value       = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_cmd_ready_low", 32'(bus.cmd_ready), 0);
        reset = 1'b0;
        #1;
        check_val("rst_sp_user", 32'(sp_user), 8192);
        check_val("rst_sp_priv", 32'(sp_priv), 6144);
        check_val("rst_pc", 32'(instruction_address), 0);
        check_val("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        check_val("rst_mem_valid", 32'(bus.mem_valid), 0);
        check_val("rst_mem_last", 32'(bus.mem_last), 0);
        check_val("rst_mem_address", 32'(bus.mem_address), 0);
        check_val("rst_fault_valid", 32'(fault_valid), 0);
        check_val("rst_fault_code", 32'(fault_code), 0);

        // Directed scenarios
        do_cmd(0, 1, 3, 0, 32'd0, 0, 0);        // PUSH 3 -> 8191..8189
        do_cmd(0, 2, 4, 0, 32'd0, 0, 0);        // POP 4 with 3 items -> underflow
        do_cmd(0, 2, 3, 0, 32'd0, 0, 0);        // POP 3 -> 8189..8191
        do_cmd(0, 1, 2, 0, 32'd0, 0, 3);        // PUSH 2 with first-beat stall
        do_cmd(0, 2, 2, 0, 32'd0, 0, 0);
        do_cmd(0, 0, 0, 1, 32'd100, 0, 0);      // user write to code -> protection
        do_cmd(1, 0, 0, 1, 32'd100, 0, 0);      // privileged write -> one beat
        do_cmd(0, 0, 0, 0, 32'd100, 0, 0);      // user read of code is allowed
        do_cmd(1, 0, 0, 0, 32'h0000_4000, 0, 0);// beyond address space
        do_cmd(1, 3, 0, 0, 32'd4000, 0, 0);     // bad SP for privileged bank
        do_cmd(0, 1, 0, 0, 32'd0, 0, 0);        // count 0 push
        do_cmd(1, 3, 0, 0, 32'd4096, 0, 0);     // privileged stack full
        do_cmd(1, 1, 1, 0, 32'd0, 0, 0);        // overflow
        do_cmd(1, 2, 15, 0, 32'd0, 1, 0);       // POP 15 from full
        do_cmd(0, 3, 0, 0, 32'd8193, 0, 0);     // just above user top
        do_cmd(0, 3, 0, 0, 32'd6144, 0, 0);     // user full boundary
        do_cmd(0, 1, 1, 0, 32'd0, 0, 0);        // overflow at user full
        do_cmd(0, 3, 0, 0, 32'd8192, 0, 0);

        // Randomized commands
        for (int i = 0; i < 60; i++) begin
            op   = $urandom_range(0, 3);
            priv = 1'($urandom_range(0, 1));
            cnt  = $urandom_range(0, 15);
            wr   = 1'($urandom_range(0, 1));
            base = priv ? 4096 : 6144;
            top  = base + 2048;
            sel  = $urandom_range(0, 4);
            if (op == 3) begin
                case (sel)
                    0: addr = 32'(base - 1);
                    1: addr = 32'(base + $urandom_range(0, 12));
                    2: addr = 32'(top);
                    3: addr = 32'(top + 1);
                    default: addr = 32'(top - $urandom_range(0, 12));
                endcase
            end else if (op == 0) begin
                case (sel)
                    0: addr = 32'($urandom_range(0, 4095));
                    1: addr = 32'($urandom_range(4096, 6143));
                    2: addr = 32'($urandom_range(6144, 16383));
                    3: addr = 32'h4000 + 32'($urandom_range(0, 255));
                    default: addr = $urandom;
                endcase
            end else begin
                addr = $urandom;
            end
            do_cmd(priv, op, cnt, wr, addr, 1, 0);
        end

        // Reset in the middle of a burst abandons it
        do_cmd(0, 3, 0, 0, 32'd8192, 0, 0);
        privilege_mode_flag = 1'b0;
        bus.cmd_valid       = 1'b1;
        bus.cmd_op          = 2'd1;
        bus.cmd_count       = 4'd3;
        bus.mem_ready       = 1'b0;
        @(posedge clock); #1;
        bus.cmd_valid = 1'b0;
        check_val("midburst_valid", 32'(bus.mem_valid), 1);
        reset = 1'b1;
        @(posedge clock); #1;
        model_reset();
        check_val("midburst_cmd_ready_low", 32'(bus.cmd_ready), 0);
        check_val("midburst_mem_valid", 32'(bus.mem_valid), 0);
        check_val("midburst_sp_user", 32'(sp_user), 32'(m_sp_user));
        reset = 1'b0;
        @(posedge clock); #1;
        check_val("midburst_cmd_ready", 32'(bus.cmd_ready), 1);
        do_cmd(0, 1, 2, 0, 32'd0, 1, 0);

        // PC: load wins over stall, then random load/stall/increment
        pc_load = 1'b1; pc_stall = 1'b1; pc_load_value = 14'h200;
        @(posedge clock); #1;
        check_val("pc_load_over_stall", 32'(instruction_address), 32'h200);
        m_pc = 32'h200;
        for (int i = 0; i < 40; i++) begin
            ld = ($urandom_range(0, 3) == 0);
            st = ($urandom_range(0, 2) == 0);
            v  = AW'($urandom_range(0, 16383));
            pc_load = ld; pc_stall = st; pc_load_value = v;
            @(posedge clock); #1;
            if (ld)       m_pc = int'(v);
            else if (!st) m_pc = (m_pc + 1) % 16384;
            check_val("pc_random", 32'(instruction_address), 32'(m_pc));
        end
        pc_load = 1'b1; pc_stall = 1'b0; pc_load_value = 14'h3FFF;
        @(posedge clock); #1;
        check_val("pc_load_top", 32'(instruction_address), 32'h3FFF);
        pc_load = 1'b0;
        m_pc = 32'h3FFF;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            m_pc = (m_pc + 1) % 16384;
            check_val("pc_wrap", 32'(instruction_address), 32'(m_pc));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
